fetch_unit: RTL and testbench



---
 rtl/core_pkg.sv | 15 +
 rtl/next_pc_logic.sv | 24 ++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the multi-cycle RV32 core.
package core_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, TRAP} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: combinational next-PC selection with jalr > jal > blt > beq > sequential priority.
module next_pc_logic #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            branch_beq,
  input  logic            branch_blt,
  input  logic            branch_jal,
  input  logic            branch_jalr,
  output logic [XLEN-1:0] next_pc,
  output logic            target_misaligned
);
  logic [XLEN-1:0] rel_target;
  logic taken;
  assign rel_target = pc + imm;
  // blt arrives with beq also set, so blt must be tested first
  assign taken = branch_blt ? !alu_zero : (branch_beq & alu_zero);
  assign next_pc = branch_jalr ? (alu_result & ~XLEN'(1)) :
                   (branch_jal | taken) ? rel_target : pc + XLEN'(4);
  assign target_misaligned = |next_pc[1:0];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and instruction fetch over a req/ready handshake, trapping on misaligned targets.
module fetch_unit
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            stall,
  input  logic            BranchBeq,
  input  logic            BranchBlt,
  input  logic            BranchJal,
  input  logic            BranchJalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            misaligned
);
  fetch_state_t state, state_next;
  logic [XLEN-1:0] next_pc;
  logic target_misaligned;
  logic advance;

  next_pc_logic #(.XLEN(XLEN)) u_next_pc (
    .pc(pc),
    .imm(imm),
    .alu_result(alu_result),
    .alu_zero(alu_zero),
    .branch_beq(BranchBeq),
    .branch_blt(BranchBlt),
    .branch_jal(BranchJal),
    .branch_jalr(BranchJalr),
    .next_pc(next_pc),
    .target_misaligned(target_misaligned)
  );

  assign advance = (state == ISSUE) && !stall;
  assign imem_addr = pc;
  assign pc_plus4 = pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      instruction <= NOP_INSTR;
      misaligned <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FETCH && imem_ready) instruction <= imem_rdata;
      if (advance) pc <= next_pc;
      if (advance && target_misaligned) misaligned <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    imem_req = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        state_next = imem_ready ? ISSUE : FETCH;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        state_next = stall ? ISSUE : (target_misaligned ? TRAP : FETCH);
      end
      default: state_next = TRAP;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] imem_addr;
  logic imem_req;
  logic imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic stall = 1'b0;
  logic BranchBeq = 1'b0, BranchBlt = 1'b0, BranchJal = 1'b0, BranchJalr = 1'b0;
  logic [31:0] imm = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic alu_zero = 1'b0;
  logic misaligned;
  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
    .BranchBeq(BranchBeq), .BranchBlt(BranchBlt), .BranchJal(BranchJal),
    .BranchJalr(BranchJalr), .imm(imm), .alu_result(alu_result),
    .alu_zero(alu_zero), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    BranchBeq = 0; BranchBlt = 0; BranchJal = 0; BranchJalr = 0;
    imm = 0; alu_result = 0; alu_zero = 0; stall = 0;
  endtask

  task automatic do_reset();
    clear_strobes();
    imem_ready = 0;
    reset = 1;
    step();
    step();
    reset = 0;
    step();
  endtask

  task automatic fetch_to_issue();
    imem_ready = 1;
    step();
    imem_ready = 0;
  endtask

  // leaves the unit in ISSUE with pc == target, reached via a jal from pc 0
  task automatic setup_at(input logic [31:0] target);
    do_reset();
    fetch_to_issue();
    BranchJal = 1;
    imm = target;
    step();
    clear_strobes();
    fetch_to_issue();
    checks++;
    if (pc !== target || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL setup_pc: pc=%h valid=%b required pc=%h valid=1", pc, instr_valid, target);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    checks++;
    if (pc !== 32'h0 || instruction !== 32'h13 || instr_valid !== 1'b0 ||
        imem_req !== 1'b0 || misaligned !== 1'b0 || pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_values: pc=%h instr=%h valid=%b req=%b mis=%b p4=%h required 0/00000013/0/0/0/4",
               pc, instruction, instr_valid, imem_req, misaligned, pc_plus4);
    end
  endtask

  task automatic test_first_fetch();
    reset = 0;
    step();
    imem_rdata = 32'h0050_0093;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait%0d: req=%b addr=%h valid=%b required 1/0/0", i, imem_req, imem_addr, instr_valid);
      end
      step();
    end
    fetch_to_issue();
    checks++;
    if (instruction !== 32'h0050_0093 || pc !== 32'h0 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL first_issue: instr=%h pc=%h valid=%b req=%b required 00500093/0/1/0",
               instruction, pc, instr_valid, imem_req);
    end
    step();
    checks++;
    if (pc !== 32'h4 || imem_addr !== 32'h4 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL next_fetch: pc=%h addr=%h req=%b required 4/4/1", pc, imem_addr, imem_req);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'h0000_0013 + 32'(i << 7);
      step();
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'(4 * i) || instruction !== imem_rdata) begin
        errors++;
        $display("FAIL seq_issue%0d: valid=%b pc=%h instr=%h required 1/%h/%h", i, instr_valid, pc, instruction, 32'(4 * i), imem_rdata);
      end
      step();
      checks++;
      if (instr_valid !== 1'b0 || pc !== 32'(4 * i + 4)) begin
        errors++;
        $display("FAIL seq_fetch%0d: valid=%b pc=%h required 0/%h", i, instr_valid, pc, 32'(4 * i + 4));
      end
    end
    imem_ready = 0;
  endtask

  task automatic test_branch(input string name, input logic [31:0] pc0, input logic jalr, input logic jal,
                             input logic blt, input logic beq, input logic zero, input logic [31:0] off,
                             input logic [31:0] alu, input logic [31:0] exp);
    setup_at(pc0);
    BranchJalr = jalr; BranchJal = jal; BranchBlt = blt; BranchBeq = beq;
    alu_zero = zero; imm = off; alu_result = alu;
    step();
    clear_strobes();
    checks++;
    if (pc !== exp || imem_addr !== exp || imem_req !== 1'b1 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL %s: pc=%h addr=%h req=%b mis=%b required %h/%h/1/0", name, pc, imem_addr, imem_req, misaligned, exp, exp);
    end
  endtask

  task automatic test_trap();
    setup_at(32'h40);
    BranchJalr = 1;
    alu_result = 32'h103;
    step();
    clear_strobes();
    imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pc !== 32'h102 || misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL trap%0d: pc=%h mis=%b req=%b valid=%b required 102/1/0/0", i, pc, misaligned, imem_req, instr_valid);
      end
      step();
    end
    imem_ready = 0;
    reset = 1;
    step();
    checks++;
    if (pc !== 32'h0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL trap_reset: pc=%h mis=%b required 0/0", pc, misaligned);
    end
    reset = 0;
  endtask

  task automatic test_stall();
    imem_rdata = 32'h0080_006F;
    setup_at(32'h20);
    BranchJal = 1;
    imm = 32'h100;
    stall = 1;
    imem_rdata = 32'hDEAD_BEEF;
    imem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pc !== 32'h20 || instruction !== 32'h0080_006F || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d: pc=%h instr=%h req=%b valid=%b required 20/0080006f/0/1", i, pc, instruction, imem_req, instr_valid);
      end
    end
    imem_ready = 0;
    stall = 0;
    step();
    clear_strobes();
    checks++;
    if (pc !== 32'h120 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: pc=%h req=%b required 120/1", pc, imem_req);
    end
  endtask

  task automatic test_reset_mid_fetch();
    setup_at(32'h80);
    step();
    reset = 1;
    imem_ready = 1;
    imem_rdata = 32'hCAFE_F00D;
    step();
    checks++;
    if (instruction !== 32'h13 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch: instr=%h pc=%h req=%b valid=%b required 00000013/0/0/0", instruction, pc, imem_req, instr_valid);
    end
    reset = 0;
    imem_ready = 0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch("beq_taken", 32'h10, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'h0, 32'h08);
    test_branch("beq_not_taken", 32'h10, 0, 0, 0, 1, 0, 32'hFFFF_FFF8, 32'h0, 32'h14);
    test_branch("blt_taken", 32'h20, 0, 0, 1, 1, 0, 32'h10, 32'h1, 32'h30);
    test_branch("blt_not_taken", 32'h20, 0, 0, 1, 1, 1, 32'h10, 32'h0, 32'h24);
    test_branch("jalr_over_jal", 32'h10, 1, 1, 0, 0, 0, 32'h40, 32'h201, 32'h200);
    test_branch("jal_over_beq", 32'h10, 0, 1, 0, 1, 0, 32'h40, 32'h0, 32'h50);
    test_branch("wrap_seq", 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    test_trap();
    test_stall();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
